// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline stall/flush/bubble and forwarding control for the 5-stage core.
// Latency: all controls are combinational (0 cycles) from inputs and registered FSM state.
// Backpressure: an unacknowledged data-memory access freezes the whole pipe; timeout -> sticky ERR.
//
// Ports:
//   clk, reset              : clock, synchronous active-high reset
//   id_rs1/id_rs2           : IF/ID source registers
//   ex_rs1/ex_rs2/ex_rd     : ID/EX register fields; ex_memread, ex_regwrite control bits
//   mem_rd, mem_regwrite    : EX/MEM destination; mem_req = MemRead | MemWrite
//   wb_rd, wb_regwrite      : MEM/WB destination
//   mem_ack                 : data memory completes the EX/MEM access this cycle
//   redirect                : taken branch/jump resolved in EX
//   *_stall / *_flush / mem_wb_bubble : pipeline register and PC controls
//   fwd_a/fwd_b             : 00 regfile, 10 EX/MEM result, 01 MEM/WB value
//   mem_timeout_err         : high while the FSM is in ERR
//
// Config macro HAZARD_FWD_EN: defined -> forwarding enabled; undefined -> no forwarding,
// every RAW hazard against ID/EX or EX/MEM stalls the front end instead.
module hazard_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic [4:0] ex_rs1,
  input  logic [4:0] ex_rs2,
  input  logic [4:0] ex_rd,
  input  logic       ex_memread,
  input  logic       ex_regwrite,
  input  logic [4:0] mem_rd,
  input  logic       mem_regwrite,
  input  logic       mem_req,
  input  logic [4:0] wb_rd,
  input  logic       wb_regwrite,
  input  logic       mem_ack,
  input  logic       redirect,
  output logic       pc_stall,
  output logic       if_id_stall,
  output logic       id_ex_stall,
  output logic       ex_mem_stall,
  output logic       if_id_flush,
  output logic       id_ex_flush,
  output logic       mem_wb_bubble,
  output logic [1:0] fwd_a,
  output logic [1:0] fwd_b,
  output logic       mem_timeout_err
);

  localparam logic [7:0] TIMEOUT_CNT = 8'(MEM_TIMEOUT);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERR      = 2'd2
  } state_t;

  state_t     state, state_nxt;
  logic [7:0] wcnt, wcnt_nxt;
  logic       frozen;
  logic       load_use;

  // A register number names a producer hazard only when it is not x0.
  function automatic logic hit(input logic [4:0] rd, input logic [4:0] rs);
    return (rd != 5'd0) && (rd == rs);
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RUN;
      wcnt  <= 8'd0;
    end else begin
      state <= state_nxt;
      wcnt  <= wcnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    wcnt_nxt  = wcnt;
    case (state)
      RUN: begin
        if (mem_req && !mem_ack) begin
          state_nxt = MEM_WAIT;
          wcnt_nxt  = 8'd1;
        end
      end
      MEM_WAIT: begin
        if (mem_ack) begin
          state_nxt = RUN;
          wcnt_nxt  = 8'd0;
        end else if (wcnt == TIMEOUT_CNT) begin
          state_nxt = ERR;
        end else begin
          wcnt_nxt = wcnt + 8'd1;
        end
      end
      ERR: begin
        state_nxt = ERR;
      end
      default: begin
        state_nxt = RUN;
        wcnt_nxt  = 8'd0;
      end
    endcase
  end

  // The freeze starts in the very cycle an access goes unacknowledged (still in RUN)
  // and an ack in MEM_WAIT releases it in the same cycle.
  always_comb begin
    frozen = 1'b0;
    case (state)
      RUN:      frozen = mem_req && !mem_ack;
      MEM_WAIT: frozen = !mem_ack;
      ERR:      frozen = 1'b1;
      default:  frozen = 1'b0;
    endcase
  end

  logic unused_cfg;

`ifdef HAZARD_FWD_EN
  function automatic logic [1:0] fwd_sel(input logic [4:0] rs);
    if (mem_regwrite && hit(mem_rd, rs))
      return 2'b10;
    else if (wb_regwrite && hit(wb_rd, rs))
      return 2'b01;
    else
      return 2'b00;
  endfunction

  assign load_use   = ex_memread && (hit(ex_rd, id_rs1) || hit(ex_rd, id_rs2));
  assign fwd_a      = fwd_sel(ex_rs1);
  assign fwd_b      = fwd_sel(ex_rs2);
  assign unused_cfg = ex_regwrite;
`else
  // Without forwarding the consumer waits in ID until the producer reaches MEM/WB;
  // the register file writes before it reads, so MEM/WB itself never stalls.
  assign load_use = ((ex_memread || ex_regwrite) && (hit(ex_rd, id_rs1) || hit(ex_rd, id_rs2)))
                 || (mem_regwrite && (hit(mem_rd, id_rs1) || hit(mem_rd, id_rs2)));
  assign fwd_a      = 2'b00;
  assign fwd_b      = 2'b00;
  assign unused_cfg = ^{ex_rs1, ex_rs2, wb_rd, wb_regwrite};
`endif

  // Priority: freeze, then redirect, then load-use. Redirect is ignored while frozen
  // because the EX/MEM source is held and will present it again after the release.
  always_comb begin
    pc_stall      = 1'b0;
    if_id_stall   = 1'b0;
    id_ex_stall   = 1'b0;
    ex_mem_stall  = 1'b0;
    if_id_flush   = 1'b0;
    id_ex_flush   = 1'b0;
    mem_wb_bubble = 1'b0;
    if (frozen) begin
      pc_stall      = 1'b1;
      if_id_stall   = 1'b1;
      id_ex_stall   = 1'b1;
      ex_mem_stall  = 1'b1;
      mem_wb_bubble = 1'b1;
    end else if (redirect) begin
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (load_use) begin
      pc_stall    = 1'b1;
      if_id_stall = 1'b1;
      id_ex_flush = 1'b1;
    end
  end

  assign mem_timeout_err = (state == ERR);

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed scenarios with literal expectations, then random
// stimulus compared every cycle against a behavioural model of the pipeline rules.
module tb_hazard_ctrl;
  localparam int TO = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
  logic       ex_memread, ex_regwrite, mem_regwrite, mem_req, wb_regwrite, mem_ack, redirect;
  logic       pc_stall, if_id_stall, id_ex_stall, ex_mem_stall;
  logic       if_id_flush, id_ex_flush, mem_wb_bubble, mem_timeout_err;
  logic [1:0] fwd_a, fwd_b;

  always #5 clk = ~clk;

  hazard_ctrl #(.MEM_TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
    .ex_rd(ex_rd), .ex_memread(ex_memread), .ex_regwrite(ex_regwrite),
    .mem_rd(mem_rd), .mem_regwrite(mem_regwrite), .mem_req(mem_req),
    .wb_rd(wb_rd), .wb_regwrite(wb_regwrite), .mem_ack(mem_ack), .redirect(redirect),
    .pc_stall(pc_stall), .if_id_stall(if_id_stall), .id_ex_stall(id_ex_stall),
    .ex_mem_stall(ex_mem_stall), .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .mem_wb_bubble(mem_wb_bubble), .fwd_a(fwd_a), .fwd_b(fwd_b),
    .mem_timeout_err(mem_timeout_err)
  );

  // [11]pc_stall [10]if_id_stall [9]id_ex_stall [8]ex_mem_stall [7]if_id_flush
  // [6]id_ex_flush [5]mem_wb_bubble [4:3]fwd_a [2:1]fwd_b [0]mem_timeout_err
  wire [11:0] outs = {pc_stall, if_id_stall, id_ex_stall, ex_mem_stall, if_id_flush,
                      id_ex_flush, mem_wb_bubble, fwd_a, fwd_b, mem_timeout_err};

  int checks = 0;
  int errors = 0;
  bit started = 1'b0;

  // Model: length of the current unacknowledged-access freeze and the error flag.
  int run_cnt = 0;
  bit m_err = 1'b0;

  task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit hit(input logic [4:0] rd, input logic [4:0] rs);
    return (rd != 5'd0) && (rd == rs);
  endfunction

  function automatic bit frz_now();
    if (m_err) return 1'b1;
    if (run_cnt > 0) return !mem_ack;
    return mem_req && !mem_ack;
  endfunction

  function automatic logic [1:0] fwd_of(input logic [4:0] rs);
`ifdef HAZARD_FWD_EN
    if (mem_regwrite && hit(mem_rd, rs)) return 2'b10;
    if (wb_regwrite && hit(wb_rd, rs)) return 2'b01;
`endif
    return 2'b00;
  endfunction

  function automatic logic [11:0] expect_outs();
    bit lu;
    logic [11:0] e;
`ifdef HAZARD_FWD_EN
    lu = ex_memread && (hit(ex_rd, id_rs1) || hit(ex_rd, id_rs2));
`else
    lu = (ex_regwrite && (hit(ex_rd, id_rs1) || hit(ex_rd, id_rs2)))
      || (mem_regwrite && (hit(mem_rd, id_rs1) || hit(mem_rd, id_rs2)));
`endif
    e = '0;
    e[4:3] = fwd_of(ex_rs1);
    e[2:1] = fwd_of(ex_rs2);
    e[0]   = m_err;
    if (frz_now()) begin
      e[11:8] = 4'hF;
      e[5]    = 1'b1;
    end else if (redirect) begin
      e[7] = 1'b1;
      e[6] = 1'b1;
    end else if (lu) begin
      e[11] = 1'b1;
      e[10] = 1'b1;
      e[6]  = 1'b1;
    end
    return e;
  endfunction

  // Model advances on the edge using the inputs held through it.
  always @(posedge clk) begin
    if (reset) begin
      m_err   = 1'b0;
      run_cnt = 0;
    end else if (!m_err) begin
      if (frz_now()) begin
        run_cnt++;
        if (run_cnt == TO + 1) m_err = 1'b1;
      end else begin
        run_cnt = 0;
      end
    end
    started = 1'b1;
  end

  always @(negedge clk) begin
    if (started) check("cycle", outs, expect_outs());
  end

  task automatic clear_in();
    {id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd} = '0;
    {ex_memread, ex_regwrite, mem_regwrite, mem_req, wb_regwrite, mem_ack, redirect} = '0;
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic lit(input string name, input logic [11:0] exp);
    @(negedge clk);
    check(name, outs, exp);
  endtask

  initial begin
    clear_in();
    reset = 1'b1;
    lit("reset_outs", 12'h000);
    next();
    reset = 1'b0;
    lit("idle_outs", 12'h000);

    // Load x5 in EX, add x6,x5,x1 in ID: one stall cycle.
    next(); ex_memread = 1; ex_regwrite = 1; ex_rd = 5; id_rs1 = 5; id_rs2 = 1;
    lit("load_use", 12'hC40);
    // Bubble in EX/MEM, load in MEM/WB, add in EX.
    next(); clear_in(); ex_rs1 = 5; ex_rs2 = 1; wb_rd = 5; wb_regwrite = 1;
`ifdef HAZARD_FWD_EN
    lit("fwd_a_wb", 12'h008);
`else
    lit("fwd_a_wb", 12'h000);
`endif

    // EX/MEM wins over MEM/WB for the same register.
    next(); clear_in(); mem_rd = 7; wb_rd = 7; mem_regwrite = 1; wb_regwrite = 1; ex_rs2 = 7;
`ifdef HAZARD_FWD_EN
    lit("fwd_b_mem", 12'h004);
`else
    lit("fwd_b_mem", 12'h000);
`endif
    next(); mem_rd = 0; wb_rd = 0; ex_rs1 = 0; ex_rs2 = 0;
    lit("fwd_x0", 12'h000);

    // Redirect wins over a simultaneous load-use hazard.
    next(); clear_in(); ex_memread = 1; ex_regwrite = 1; ex_rd = 9; id_rs2 = 9; redirect = 1;
    lit("redirect_lu", 12'h0C0);

    // Access unacknowledged for 4 cycles (RUN + 3 waits), then ack.
    next(); clear_in(); mem_req = 1;
    for (int i = 0; i < 4; i++) begin
      lit("mem_wait", 12'hF20);
      next();
    end
    mem_ack = 1;
    lit("mem_ack_release", 12'h000);
    next(); clear_in();
    lit("after_ack", 12'h000);

    // Redirect held during a wait is ignored, then honoured on the ack cycle.
    next(); mem_req = 1; redirect = 1;
    lit("redir_wait0", 12'hF20);
    next();
    lit("redir_wait1", 12'hF20);
    next(); mem_ack = 1;
    lit("redir_release", 12'h0C0);

    // Timeout: TO+1 frozen cycles, then ERR until reset.
    next(); clear_in(); mem_req = 1;
    for (int i = 0; i < TO + 1; i++) begin
      lit("pre_timeout", 12'hF20);
      next();
    end
    lit("timeout_err", 12'hF21);
    next(); mem_ack = 1; mem_req = 0;
    lit("err_sticky", 12'hF21);
    next(); clear_in(); reset = 1;
    next(); reset = 0;
    lit("err_cleared", 12'h000);

    // Random traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      next();
      reset        = ($urandom_range(0, 99) == 0);
      id_rs1       = 5'($urandom_range(0, 7));
      id_rs2       = 5'($urandom_range(0, 7));
      ex_rs1       = 5'($urandom_range(0, 7));
      ex_rs2       = 5'($urandom_range(0, 7));
      ex_rd        = 5'($urandom_range(0, 7));
      mem_rd       = 5'($urandom_range(0, 7));
      wb_rd        = 5'($urandom_range(0, 7));
      ex_memread   = ($urandom_range(0, 3) == 0);
      ex_regwrite  = ex_memread || ($urandom_range(0, 1) == 1);
      mem_regwrite = ($urandom_range(0, 1) == 1);
      wb_regwrite  = ($urandom_range(0, 1) == 1);
      mem_req      = ($urandom_range(0, 2) == 0);
      mem_ack      = ($urandom_range(0, 1) == 1);
      redirect     = ($urandom_range(0, 5) == 0);
    end

    next();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
